// File: rtl/traffic_pkg.sv
// traffic_pkg: shared channel state encoding and default detector timing constants
package traffic_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    QUAL   = 3'd1,
    ACTIVE = 3'd2,
    HOLD   = 3'd3,
    FAULT  = 3'd4
  } ch_state_t;
  localparam int unsigned DEF_DEB_CYCLES    = 4;
  localparam int unsigned DEF_HOLD_CYCLES   = 3;
  localparam int unsigned DEF_MAX_ON_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W         = 16;
endpackage

// File: rtl/traffic_sensor_channel.sv
// traffic_sensor_channel: sync, debounce, hold-stretch and stuck detection for one loop detector
module traffic_sensor_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned MAX_ON_CYCLES = DEF_MAX_ON_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic fault
);
  logic s1, s2;
  ch_state_t state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      case (state)
        IDLE:
          if (s2) begin
            state <= QUAL;
            cnt   <= CNT_W'(1);
          end
        QUAL:
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            state <= ACTIVE;
            cnt   <= '0;
          end else cnt <= cnt + CNT_W'(1);
        ACTIVE:
          if (!s2) begin
            state <= HOLD;
            cnt   <= CNT_W'(1);
          end else if (cnt == CNT_W'(MAX_ON_CYCLES - 1)) begin
            state <= FAULT;
            cnt   <= '0;
          end else cnt <= cnt + CNT_W'(1);
        HOLD:
          if (s2) begin
            state <= ACTIVE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(HOLD_CYCLES)) begin
            state <= IDLE;
            cnt   <= '0;
          end else cnt <= cnt + CNT_W'(1);
        FAULT:
          // leaving FAULT needs a debounced low, so a flickering stuck loop stays flagged
          if (s2) cnt <= '0;
          else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else cnt <= cnt + CNT_W'(1);
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  assign out   = (state == ACTIVE) || (state == HOLD) || (state == FAULT);
  assign fault = (state == FAULT);
endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: two independent conditioned presence channels for roads A and B
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned MAX_ON_CYCLES = DEF_MAX_ON_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  output logic sa,
  output logic sb,
  output logic fault_a,
  output logic fault_b
);
  traffic_sensor_channel #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .MAX_ON_CYCLES(MAX_ON_CYCLES), .CNT_W(CNT_W)
  ) u_a (
    .clk(clk), .rst_n(reset), .raw(raw_a), .out(sa), .fault(fault_a)
  );
  traffic_sensor_channel #(
    .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .MAX_ON_CYCLES(MAX_ON_CYCLES), .CNT_W(CNT_W)
  ) u_b (
    .clk(clk), .rst_n(reset), .raw(raw_b), .out(sb), .fault(fault_b)
  );
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: directed edge-by-edge traces with a queued expected-output scoreboard
module tb_traffic_sensor_conditioner;
  logic clk, reset, raw_a, raw_b;
  logic sa, sb, fault_a, fault_b;
  int checks = 0;
  int errors = 0;
  logic [3:0] sb_q[$];
  traffic_sensor_conditioner #(
    .DEB_CYCLES(4), .HOLD_CYCLES(3), .MAX_ON_CYCLES(20), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b),
    .sa(sa), .sb(sb), .fault_a(fault_a), .fault_b(fault_b)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // raws set here are sampled at the next edge; expected is {sa,sb,fault_a,fault_b} just after it
  task automatic step(input string tag, input int e, input logic ra, input logic rb,
                      input logic [3:0] exp);
    logic [3:0] obs, want;
    raw_a = ra;
    raw_b = rb;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    obs  = {sa, sb, fault_a, fault_b};
    want = sb_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s e=%0d observed=%b expected=%b", tag, e, obs, want);
    end
  endtask
  task automatic check_now(input string tag, input logic [3:0] exp);
    checks++;
    assert ({sa, sb, fault_a, fault_b} === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, {sa, sb, fault_a, fault_b}, exp);
    end
  endtask
  task automatic pad(input string tag, input int n);
    for (int e = 0; e < n; e++) step(tag, e, 1'b0, 1'b0, 4'b0000);
  endtask
  initial begin
    reset = 1'b0;
    raw_a = 1'b0;
    raw_b = 1'b0;
    #12;
    check_now("reset_state", 4'b0000);
    #10 reset = 1'b1;
    // clean rise at sample 10, fall sampled at 18
    for (int e = 0; e < 25; e++)
      step("clean_rise", e, e >= 10 && e < 18, 1'b0, {e >= 15 && e <= 22, 3'b000});
    pad("pad1", 4);
    // three high samples must never qualify
    for (int e = 0; e < 12; e++)
      step("glitch", e, e >= 2 && e <= 4, 1'b0, 4'b0000);
    // two-sample low pulse is absorbed by hold; exact rise latency proves IDLE after glitch
    for (int e = 0; e < 26; e++)
      step("hold_bounce", e, e < 18 && e != 10 && e != 11, 1'b0, {e >= 5 && e <= 22, 3'b000});
    pad("pad2", 4);
    for (int e = 0; e < 40; e++)
      step("stuck", e, 1'b0, e < 30, {1'b0, e >= 5 && e <= 34, 1'b0, e >= 25 && e <= 34});
    pad("pad3", 4);
    for (int e = 0; e < 30; e++)
      step("pre_reset", e, e >= 10, 1'b1, {e >= 15, e >= 5, 1'b0, e >= 25});
    #3 reset = 1'b0;
    #1;
    check_now("async_reset", 4'b0000);
    for (int e = 0; e < 2; e++) step("reset_held", e, 1'b1, 1'b1, 4'b0000);
    #3 reset = 1'b1;
    for (int e = 0; e < 10; e++)
      step("post_reset", e, 1'b1, 1'b1, {e >= 5, e >= 5, 2'b00});
    for (int e = 0; e < 10; e++)
      step("post_fall", e, 1'b0, 1'b0, {e <= 4, e <= 4, 2'b00});
    pad("pad4", 4);
    for (int e = 0; e < 30; e++)
      step("indep", e, e <= 11, (e >= 2 && e <= 4) || (e >= 8 && e <= 19 && e != 14),
           {e >= 5 && e <= 16, e >= 13 && e <= 24, 2'b00});
    pad("pad5", 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
